// File: rtl/enums_conv_layer.sv
// rtl/enums_conv_layer.sv - shared convolution-layer enums (padding mode, read scheduler states)
package enums_conv_layer;

  typedef enum logic {
    SAME  = 1'b0,
    VALID = 1'b1
  } padding_type;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ROW = 2'd1,
    ISSUE    = 2'd2,
    DONE     = 2'd3
  } sched_state_e;

endpackage

// File: rtl/lb_read_scheduler_pkg.sv
// rtl/lb_read_scheduler_pkg.sv - constants and helpers for the line-buffer read scheduler
package lb_read_scheduler_pkg;

  localparam int STALL_CNT_WIDTH = 16;

  // Distance from the kernel centre to its edge.
  function automatic int half_kernel(input int k);
    return (k - 1) / 2;
  endfunction

endpackage

// File: rtl/lb_read_scheduler_if.sv
// rtl/lb_read_scheduler_if.sv - scheduler to OCU position handshake
interface lb_read_scheduler_if #(
  parameter int COLADDRESSWIDTH = 5,
  parameter int ROWADDRESSWIDTH = 5
);

  logic                       ready_o;
  logic [COLADDRESSWIDTH-1:0] read_col_o;
  logic [ROWADDRESSWIDTH-1:0] read_row_o;
  logic                       last_o;
  logic                       ocu_ready_i;

  modport master (
    output ready_o,
    output read_col_o,
    output read_row_o,
    output last_o,
    input  ocu_ready_i
  );

  modport slave (
    input  ready_o,
    input  read_col_o,
    input  read_row_o,
    input  last_o,
    output ocu_ready_i
  );

endinterface

// File: rtl/lb_read_scheduler_axis_counter.sv
// rtl/lb_read_scheduler_axis_counter.sv - one schedule axis: start/end/stride position counter with last flag
module lb_sched_axis_counter #(
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          advance_i,
  input  logic [AW:0]   start_i,
  input  logic [AW:0]   end_i,
  input  logic [AW:0]   stride_i,
  output logic [AW-1:0] value_o,
  output logic          last_o,
  output logic          last_d_o
);

  logic [AW:0] start_q, end_q, stride_q;
  logic [AW:0] value_q, value_d;
  logic        last_q, last_d;

  // The last flag is precomputed one step ahead so it is a plain register.
  always_comb begin
    value_d = value_q;
    last_d  = last_q;
    if (load_i) begin
      value_d = start_i;
      last_d  = (start_i + stride_i) > end_i;
    end else if (advance_i) begin
      if (last_q) begin
        value_d = start_q;
        last_d  = (start_q + stride_q) > end_q;
      end else begin
        value_d = value_q + stride_q;
        last_d  = (value_q + stride_q + stride_q) > end_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q  <= '0;
      end_q    <= '0;
      stride_q <= '0;
      value_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      if (load_i) begin
        start_q  <= start_i;
        end_q    <= end_i;
        stride_q <= stride_i;
      end
      value_q <= value_d;
      last_q  <= last_d;
    end
  end

  assign value_o  = value_q[AW-1:0];
  assign last_o   = last_q;
  assign last_d_o = last_d;

endmodule

// File: rtl/lb_read_scheduler.sv
// rtl/lb_read_scheduler.sv - output-pixel (col,row) schedule for the line-buffer to OCU path; LB_READ_SCHEDULER_PERF_EN adds stall_cycles_o
module lb_read_scheduler
  import enums_conv_layer::*;
  import lb_read_scheduler_pkg::*;
#(
  parameter int K               = 3,
  parameter int IMAGEWIDTH      = 32,
  parameter int IMAGEHEIGHT     = 32,
  parameter int COLADDRESSWIDTH = $clog2(IMAGEWIDTH),
  parameter int ROWADDRESSWIDTH = $clog2(IMAGEHEIGHT)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       new_layer_i,
  input  logic [$clog2(K)-1:0]       layer_stride_width_i,
  input  logic [$clog2(K)-1:0]       layer_stride_height_i,
  input  padding_type                layer_padding_type_i,
  input  logic [COLADDRESSWIDTH:0]   layer_imagewidth_i,
  input  logic [ROWADDRESSWIDTH:0]   layer_imageheight_i,
  input  logic                       row_written_i,
  lb_read_scheduler_if.master        ocu,
  output logic                       layer_done_o
`ifdef LB_READ_SCHEDULER_PERF_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles_o
`endif
);

  localparam int CW = COLADDRESSWIDTH;
  localparam int RW = ROWADDRESSWIDTH;
  localparam int SW = $clog2(K);
  localparam int P  = half_kernel(K);

  sched_state_e state_q, state_d;

  logic [SW-1:0] sw_eff, sh_eff;
  logic          is_valid, empty_in;
  logic [CW:0]   col_start, col_end;
  logic [RW:0]   row_start, row_end;

  logic          empty_q;
  logic [RW:0]   height_q, rows_written_q, row_need;
  logic          row_avail;
  logic          col_adv, row_adv;

  logic [CW-1:0] col_value;
  logic [RW-1:0] row_value;
  logic          col_last, col_last_d, row_last, row_last_d;

  logic          ready_q, last_q, done_q;

  assign sw_eff   = (layer_stride_width_i  == '0) ? SW'(1) : layer_stride_width_i;
  assign sh_eff   = (layer_stride_height_i == '0) ? SW'(1) : layer_stride_height_i;
  assign is_valid = (layer_padding_type_i == VALID);

  assign col_start = is_valid ? (CW+1)'(P) : '0;
  assign col_end   = is_valid ? layer_imagewidth_i - (CW+1)'(P + 1) : layer_imagewidth_i - (CW+1)'(1);
  assign row_start = is_valid ? (RW+1)'(P) : '0;
  assign row_end   = is_valid ? layer_imageheight_i - (RW+1)'(P + 1) : layer_imageheight_i - (RW+1)'(1);

  // A VALID layer smaller than the kernel has no centre positions at all.
  assign empty_in = is_valid && ((layer_imagewidth_i  < (CW+1)'(K)) ||
                                 (layer_imageheight_i < (RW+1)'(K)));

  assign col_adv = (state_q == ISSUE) && ocu.ocu_ready_i && !new_layer_i;
  assign row_adv = col_adv && col_last;

  lb_sched_axis_counter #(.AW(CW)) u_col (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (new_layer_i),
    .advance_i (col_adv),
    .start_i   (col_start),
    .end_i     (col_end),
    .stride_i  ((CW+1)'(sw_eff)),
    .value_o   (col_value),
    .last_o    (col_last),
    .last_d_o  (col_last_d)
  );

  lb_sched_axis_counter #(.AW(RW)) u_row (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (new_layer_i),
    .advance_i (row_adv),
    .start_i   (row_start),
    .end_i     (row_end),
    .stride_i  ((RW+1)'(sh_eff)),
    .value_o   (row_value),
    .last_o    (row_last),
    .last_d_o  (row_last_d)
  );

  // Row r needs the rows below its centre written; the bottom rows clamp at H.
  assign row_need  = {1'b0, row_value} + (RW+1)'(P + 1);
  assign row_avail = rows_written_q >= ((row_need > height_q) ? height_q : row_need);

  always_comb begin
    state_d = state_q;
    if (new_layer_i) begin
      state_d = WAIT_ROW;
    end else begin
      case (state_q)
        IDLE:     state_d = IDLE;
        WAIT_ROW: begin
          if (empty_q)        state_d = DONE;
          else if (row_avail) state_d = ISSUE;
        end
        ISSUE: begin
          if (ocu.ocu_ready_i && col_last) state_d = row_last ? DONE : WAIT_ROW;
        end
        DONE:     state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      ready_q        <= 1'b0;
      last_q         <= 1'b0;
      done_q         <= 1'b0;
      empty_q        <= 1'b0;
      height_q       <= '0;
      rows_written_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ISSUE);
      last_q  <= (state_d == ISSUE) && col_last_d && row_last_d;
      done_q  <= (state_d == DONE);
      if (new_layer_i) begin
        empty_q        <= empty_in;
        height_q       <= layer_imageheight_i;
        rows_written_q <= '0;
      end else if (((state_q == WAIT_ROW) || (state_q == ISSUE)) && row_written_i &&
                   (rows_written_q < height_q)) begin
        rows_written_q <= rows_written_q + (RW+1)'(1);
      end
    end
  end

  assign ocu.ready_o    = ready_q;
  assign ocu.read_col_o = col_value;
  assign ocu.read_row_o = row_value;
  assign ocu.last_o     = last_q;
  assign layer_done_o   = done_q;

`ifdef LB_READ_SCHEDULER_PERF_EN
  logic [STALL_CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (new_layer_i) begin
      stall_q <= '0;
    end else if ((((state_q == ISSUE) && !ocu.ocu_ready_i) || (state_q == WAIT_ROW)) &&
                 (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_WIDTH'(1);
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule
